// File: rtl/conv_row_serializer.sv
// conv_row_serializer
//
// Output-side reader for the convolution engine. It takes one full-width
// result row per handshake and drains it as a stream of OUT_W-bit pixels,
// least-significant pixel first. It also tracks the row position within a
// frame, so that the last pixel of each row and of each frame can be flagged.
//
// Parameters
//   ROW_W          width of one input row in bits (integer multiple of OUT_W)
//   OUT_W          width of one output pixel in bits
//   ROWS_PER_FRAME rows per frame, used for out_frame_last
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   row_valid      row_data holds a valid row
//   row_data       result row from the conv engine
//   row_ready      block can take a row this cycle
//   out_valid      out_data holds a valid pixel
//   out_data       current pixel (low OUT_W bits of the row buffer)
//   out_ready      downstream takes the pixel this cycle
//   out_row_last   current pixel is the last pixel of its row
//   out_frame_last current pixel is the last pixel of the last row of a frame
//   busy           a row is held (same as out_valid)

module conv_row_serializer #(
  parameter int ROW_W          = 1024,
  parameter int OUT_W          = 8,
  parameter int ROWS_PER_FRAME = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row_data,
  output logic             row_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_row_last,
  output logic             out_frame_last,
  output logic             busy
);

  localparam int WORDS = ROW_W / OUT_W;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RCW   = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

  localparam logic [WCW-1:0] LAST_WORD = WCW'(WORDS - 1);
  localparam logic [RCW-1:0] LAST_ROW  = RCW'(ROWS_PER_FRAME - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] rowBuf_q, rowBuf_d;
  logic [WCW-1:0]   wordCnt_q, wordCnt_d;
  logic [RCW-1:0]   rowCnt_q, rowCnt_d;
  logic             rowReadyInt;
  logic             lastWord;

  assign lastWord = (wordCnt_q == LAST_WORD);

  // State and datapath registers. Reset wins over everything, so a row that
  // is only partly drained is simply dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rowBuf_q  <= '0;
      wordCnt_q <= '0;
      rowCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      rowBuf_q  <= rowBuf_d;
      wordCnt_q <= wordCnt_d;
      rowCnt_q  <= rowCnt_d;
    end
  end

  // Next-state logic. While shifting, the block is ready for a new row only
  // in the cycle where the last pixel leaves, which lets a waiting row load
  // on that same edge and keeps the output stream free of bubbles.
  always_comb begin
    state_d     = state_q;
    rowBuf_d    = rowBuf_q;
    wordCnt_d   = wordCnt_q;
    rowCnt_d    = rowCnt_q;
    rowReadyInt = 1'b0;

    case (state_q)
      IDLE: begin
        rowReadyInt = 1'b1;
        if (row_valid) begin
          rowBuf_d  = row_data;
          wordCnt_d = '0;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        rowReadyInt = lastWord && out_ready;
        if (out_ready) begin
          if (!lastWord) begin
            rowBuf_d  = rowBuf_q >> OUT_W;
            wordCnt_d = wordCnt_q + WCW'(1);
          end else begin
            rowCnt_d = (rowCnt_q == LAST_ROW) ? '0 : rowCnt_q + RCW'(1);
            if (row_valid) begin
              rowBuf_d  = row_data;
              wordCnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // row_ready is forced low while reset is asserted so nothing is offered a
  // handshake that the register reset is about to discard.
  assign row_ready      = reset && rowReadyInt;
  assign out_valid      = (state_q == SHIFT);
  assign busy           = out_valid;
  assign out_data       = rowBuf_q[OUT_W-1:0];
  assign out_row_last   = out_valid && lastWord;
  assign out_frame_last = out_row_last && (rowCnt_q == LAST_ROW);

endmodule

// File: tb/tb_conv_row_serializer.sv
// Testbench for conv_row_serializer. A reference model keeps a queue of the
// pixels still owed downstream (with their row/frame flags); every cycle the
// DUT outputs are compared against the head of that queue.

module tb_conv_row_serializer;

  localparam int ROW_W          = 1024;
  localparam int OUT_W          = 8;
  localparam int ROWS_PER_FRAME = 32;
  localparam int WORDS          = ROW_W / OUT_W;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic             rl;
    logic             fl;
  } pix_t;

  logic             clk;
  logic             reset;
  logic             row_valid;
  logic [ROW_W-1:0] row_data;
  logic             row_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_ready;
  logic             out_row_last;
  logic             out_frame_last;
  logic             busy;

  conv_row_serializer #(
    .ROW_W(ROW_W),
    .OUT_W(OUT_W),
    .ROWS_PER_FRAME(ROWS_PER_FRAME)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_valid(row_valid),
    .row_data(row_data),
    .row_ready(row_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .out_row_last(out_row_last),
    .out_frame_last(out_frame_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source rows waiting to be offered, and pixels the model still expects.
  logic [ROW_W-1:0] srcQ[$];
  pix_t             expQ[$];

  int   nAsserts      = 0;
  int   nFail         = 0;
  int   rowsAccepted  = 0;
  int   pixDone       = 0;
  int   frameLastSeen = 0;
  int   readyMode     = 0;
  logic justReset     = 1'b0;
  logic prevStall     = 1'b0;
  logic [OUT_W-1:0] prevData = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rampRow();
    logic [ROW_W-1:0] r;
    for (int k = 0; k < WORDS; k++) r[k*OUT_W +: OUT_W] = OUT_W'(k + 1);
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] fillRow(input logic [OUT_W-1:0] b);
    logic [ROW_W-1:0] r;
    for (int k = 0; k < WORDS; k++) r[k*OUT_W +: OUT_W] = b;
    return r;
  endfunction

  function automatic logic [ROW_W-1:0] randRow();
    logic [ROW_W-1:0] r;
    for (int j = 0; j < ROW_W / 32; j++) r[j*32 +: 32] = $urandom;
    return r;
  endfunction

  // Break an accepted row into its pixels, LSB pixel first, with flags.
  task automatic pushRow(input logic [ROW_W-1:0] row);
    pix_t e;
    int   idx;
    idx = rowsAccepted % ROWS_PER_FRAME;
    for (int k = 0; k < WORDS; k++) begin
      e.d  = row[k*OUT_W +: OUT_W];
      e.rl = (k == WORDS - 1);
      e.fl = (k == WORDS - 1) && (idx == ROWS_PER_FRAME - 1);
      expQ.push_back(e);
    end
    rowsAccepted++;
  endtask

  // Drive inputs just after the rising edge.
  task automatic applyStimulus();
    reset     = 1'b1;
    row_valid = (srcQ.size() > 0);
    row_data  = (srcQ.size() > 0) ? srcQ[0] : '0;
    case (readyMode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Compare on the falling edge, then advance the model by the handshakes
  // that the next rising edge will perform.
  task automatic checkOutput();
    logic expValid;
    logic expReady;
    if (!reset) begin
      check("row_ready_in_reset", 64'(row_ready), 64'(0));
      expQ.delete();
      rowsAccepted = 0;
      prevStall    = 1'b0;
      justReset    = 1'b1;
    end else begin
      expValid = (expQ.size() > 0);
      expReady = !expValid || (expQ.size() == 1 && out_ready);
      check("out_valid", 64'(out_valid), 64'(expValid));
      check("busy", 64'(busy), 64'(expValid));
      check("row_ready", 64'(row_ready), 64'(expReady));
      if (justReset) begin
        check("out_data_after_reset", 64'(out_data), 64'(0));
        check("row_last_after_reset", 64'(out_row_last), 64'(0));
        check("frame_last_after_reset", 64'(out_frame_last), 64'(0));
        justReset = 1'b0;
      end
      if (expValid) begin
        check("out_data", 64'(out_data), 64'(expQ[0].d));
        check("out_row_last", 64'(out_row_last), 64'(expQ[0].rl));
        check("out_frame_last", 64'(out_frame_last), 64'(expQ[0].fl));
        if (prevStall) check("stall_hold", 64'(out_data), 64'(prevData));
      end else begin
        check("row_last_idle", 64'(out_row_last), 64'(0));
        check("frame_last_idle", 64'(out_frame_last), 64'(0));
      end
      if (out_valid && out_ready && out_frame_last) frameLastSeen++;
      prevStall = expValid && !out_ready;
      if (expValid) prevData = expQ[0].d;
      if (expValid && out_ready) begin
        void'(expQ.pop_front());
        pixDone++;
      end
      if (expReady && row_valid) begin
        pushRow(srcQ[0]);
        void'(srcQ.pop_front());
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (srcQ.size() > 0 || expQ.size() > 0)) begin
      stepCycle();
      i++;
    end
    check("drain_timeout", 64'(srcQ.size() == 0 && expQ.size() == 0), 64'(1));
    stepCycle();
  endtask

  task automatic waitPixels(input int n, input int budget);
    int i;
    i = 0;
    while (i < budget && pixDone < n) begin
      stepCycle();
      i++;
    end
    check("pixel_wait_timeout", 64'(pixDone >= n), 64'(1));
  endtask

  initial begin
    reset     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;
    out_ready = 1'b1;

    $display("[TB] reset");
    stepCycle();
    reset = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] single row, out_ready always high");
    readyMode = 0;
    srcQ.push_back(rampRow());
    drain(400);

    $display("[TB] same row under random backpressure");
    readyMode = 1;
    srcQ.push_back(rampRow());
    drain(2000);

    $display("[TB] back-to-back rows A/B");
    readyMode = 0;
    srcQ.push_back(fillRow(8'hAA));
    srcQ.push_back(fillRow(8'h55));
    drain(600);

    $display("[TB] held row_valid while busy");
    readyMode = 1;
    pixDone = 0;
    srcQ.push_back(randRow());
    waitPixels(10, 200);
    srcQ.push_back(randRow());
    drain(2000);

    $display("[TB] reset mid-row");
    readyMode = 0;
    pixDone = 0;
    srcQ.push_back(rampRow());
    waitPixels(40, 200);
    reset     = 1'b0;
    row_valid = 1'b0;
    stepCycle();

    $display("[TB] frame wrap over 33 rows");
    readyMode = 2;
    frameLastSeen = 0;
    for (int r = 0; r < ROWS_PER_FRAME + 1; r++) srcQ.push_back(randRow());
    drain(20000);
    check("frame_last_count", 64'(frameLastSeen), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/conv_row_serializer.md
Name: conv_row_serializer

Overview:
- Output-side reader for the convolution engine. Accepts one full-width result row (1024 bits) per handshake and drains it as a stream of OUT_W-bit pixels over a valid/ready interface, least-significant pixel first.
- Tracks row position within a frame and flags the last pixel of each row and of each frame.
- Sits between the conv TOP's data_outl and the downstream writer (memory/file/UART bridge).

Parameters:
- ROW_W, 1024, width of one input row in bits.
- OUT_W, 8, width of one output pixel in bits. ROW_W must be an integer multiple of OUT_W.
- ROWS_PER_FRAME, 32, rows per frame, used for out_frame_last.

Ports:
- clk  input  1  clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- row_valid  input  1  row_data holds a valid row.
- row_data  input  ROW_W  result row from the conv engine.
- row_ready  output  1  block can accept a row this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  OUT_W  current pixel, equal to row_buf[OUT_W-1:0].
- out_ready  input  1  downstream accepts the pixel this cycle.
- out_row_last  output  1  the current pixel is the last pixel of its row.
- out_frame_last  output  1  the current pixel is the last pixel of the last row in the frame.
- busy  output  1  a row is held (equal to out_valid).

Behaviour:
- Derived value: WORDS = ROW_W/OUT_W (128 with defaults). Counters: word_cnt, clog2(WORDS) bits; row_cnt, clog2(ROWS_PER_FRAME) bits.
- Reset (reset==0 at a clock edge): state=IDLE, out_valid=0, out_data=0, row_buf=0, word_cnt=0, row_cnt=0, out_row_last=0, out_frame_last=0, busy=0, row_ready=0 in the reset cycle.
  - Reset has priority over every other event, including mid-row. A partially drained row is discarded and not resumed.
- States:
  - IDLE: row_ready=1, out_valid=0.
  - SHIFT: out_valid=1.
- Row load: row_valid && row_ready at an edge loads row_buf<=row_data and sets word_cnt=0. State becomes SHIFT. out_valid=1 from the next cycle, so latency is 1 cycle from row accept to the first pixel.
- Pixel transfer: out_valid && out_ready at an edge.
  - If word_cnt != WORDS-1: row_buf shifts right by OUT_W (zero fill) and word_cnt increments.
  - If word_cnt == WORDS-1: the row is done and row_cnt increments, wrapping to 0 after ROWS_PER_FRAME-1.
- row_ready in SHIFT = (word_cnt==WORDS-1) && out_ready. This allows back-to-back rows with no bubble.
  - If row_valid is also high, the new row loads in the same edge as the last-pixel transfer and the state stays SHIFT.
  - Otherwise the state goes to IDLE.
- row_ready is combinational from state, word_cnt and out_ready. No combinational path from row_valid to row_ready.
- Backpressure: while out_valid && !out_ready, out_data, out_row_last, out_frame_last and row_buf hold unchanged.
- out_row_last = out_valid && (word_cnt==WORDS-1).
- out_frame_last = out_row_last && (row_cnt==ROWS_PER_FRAME-1).
- row_valid while in SHIFT and not at the last word is ignored. The source must hold it; no row is lost or duplicated.
- Arithmetic: pixels are passed bit-exact; no sign handling or saturation.

Test Plan:
- Single row: row_data = {…,0x03,0x02,0x01} (byte k = k+1 mod 256), out_ready=1 constant.
  - row_ready drops the cycle after the handshake.
  - 128 consecutive pixels appear: 0x01, 0x02, …, 0x80.
  - out_row_last is high only on 0x80; the block returns to IDLE.
- Backpressure: same row, out_ready toggling 1,0,0,1… (pseudo-random).
  - Pixel sequence is identical to the single-row case with no drops or duplicates.
  - out_data is stable during every stall cycle.
- Back-to-back rows: row_valid held high with rows A (all 0xAA) and B (all 0x55), out_ready=1.
  - Output is 256 consecutive valid cycles: 128×0xAA then 128×0x55.
  - No bubble at the boundary; row_ready pulses on the cycle of A's last pixel.
- Frame wrap: 33 rows streamed.
  - out_frame_last asserts exactly once, on the 128th pixel of row 32.
  - Row 33 pixel 128 shows out_row_last=1 and out_frame_last=0 (row_cnt wrapped to 0).
- Reset mid-row: reset=0 for one cycle after pixel 40.
  - The next cycle shows out_valid=0, out_data=0, row_ready=0, then row_ready=1.
  - A new row then streams from pixel 0 with row_cnt=0.
- Held row_valid while busy: assert row_valid with row B at pixel 10 of row A.
  - B is not accepted until A's last pixel.
  - A is fully output before B.
